// File: rtl/determ_pkg.sv
// Shared types and fixed-point helpers for the deterministic bitstream blocks.
// All blocks use the same signed fixed-point format, with ONE = 2^FRAC.
package determ_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // +1.0 in a format with int_width integer bits plus a sign bit
  function automatic int one_fx(input int bit_width, input int int_width);
    return 1 << (bit_width - int_width - 1);
  endfunction

  // Clamp a fixed-point value to the unit interval [-one, one]
  function automatic int sat_unit(input int x, input int one);
    if (x > one)  return one;
    if (x < -one) return -one;
    return x;
  endfunction

endpackage

// File: rtl/determ_encode.sv
// Fixed-point to deterministic bipolar bitstream encoder (first-order sigma-delta).
// One value in, STREAM_LEN bits out; the running mean of the bits tracks the value.
module determ_encode
  import determ_pkg::*;
#(
  parameter int BIT_WIDTH  = 16,
  parameter int INT_WIDTH  = 1,
  parameter int STREAM_LEN = 256,
  parameter int CNT_WIDTH  = 9
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [BIT_WIDTH-1:0] x_in,
  input  logic                 x_valid,
  output logic                 x_ready,
  output logic                 bit_out,
  output logic                 bit_valid,
  input  logic                 bit_ready,
  output logic                 bit_last
);

  localparam int AW    = BIT_WIDTH + 2;
  localparam int ONE_I = one_fx(BIT_WIDTH, INT_WIDTH);
  localparam logic signed [AW-1:0]  ONE_A    = AW'(ONE_I);
  localparam logic [CNT_WIDTH-1:0]  LAST_CNT = CNT_WIDTH'(STREAM_LEN - 1);

  state_t                      state, state_nx;
  logic signed [BIT_WIDTH-1:0] x_reg, x_nx, x_sat;
  logic signed [AW-1:0]        acc, acc_nx, x_ext, sum;
  logic [CNT_WIDTH-1:0]        cnt, cnt_nx;
  logic                        bit_hs;

  assign x_sat = BIT_WIDTH'(sat_unit(int'($signed(x_in)), ONE_I));

  // Two guard bits: |acc| <= ONE and |x_reg| <= ONE, so |sum| <= 2*ONE never overflows.
  assign x_ext = {{2{x_reg[BIT_WIDTH-1]}}, x_reg};
  assign sum   = acc + x_ext;

  assign x_ready   = (state == IDLE);
  assign bit_valid = (state == RUN);
  assign bit_out   = (state == RUN) && !sum[AW-1];
  assign bit_last  = (state == RUN) && (cnt == LAST_CNT);
  assign bit_hs    = bit_valid && bit_ready;

  // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    x_nx     = x_reg;
    acc_nx   = acc;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (x_valid) begin
          x_nx     = x_sat;
          acc_nx   = '0;
          cnt_nx   = '0;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (bit_hs) begin
          acc_nx = bit_out ? (sum - ONE_A) : (sum + ONE_A);
          cnt_nx = cnt + CNT_WIDTH'(1);
          if (bit_last) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so all state updates see pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      x_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      x_reg <= x_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_determ_encode.sv
// Directed self-checking bench for determ_encode at default parameters.
// Expected streams are hand-derived periodic patterns and ones counts.
module tb_determ_encode;

  localparam int LEN    = 256;
  localparam int BUDGET = 4000;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [15:0] x_in = '0;
  logic        x_valid = 1'b0;
  logic        bit_ready = 1'b0;
  logic        x_ready, bit_out, bit_valid, bit_last;

  int n_checks = 0;
  int n_pass   = 0;

  logic [LEN-1:0] s_bits;
  int             s_n, s_last_cnt, s_last_idx;
  bit             s_stall_bad, s_valid_bad, s_timeout;

  determ_encode #(
    .BIT_WIDTH (16),
    .INT_WIDTH (1),
    .STREAM_LEN(LEN),
    .CNT_WIDTH (9)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .x_in     (x_in),
    .x_valid  (x_valid),
    .x_ready  (x_ready),
    .bit_out  (bit_out),
    .bit_valid(bit_valid),
    .bit_ready(bit_ready),
    .bit_last (bit_last)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [LEN-1:0] obs, input logic [LEN-1:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Periodic expected stream; pat bit 0 is the first emitted bit
  function automatic logic [LEN-1:0] pattern(input logic [7:0] pat, input int period);
    logic [LEN-1:0] v;
    for (int i = 0; i < LEN; i++) v[i] = pat[i % period];
    return v;
  endfunction

  // Accept x, then collect up to max_bits handshaken bits (optionally stalling and poking x_valid)
  task automatic run_stream(input string tag, input logic [15:0] x, input bit stall, input int max_bits);
    logic [2:0] prev;
    bit         held;
    int         cycles;
    s_bits = '0; s_n = 0; s_last_cnt = 0; s_last_idx = -1;
    s_stall_bad = 0; s_valid_bad = 0; s_timeout = 0;
    held = 0; prev = '0; cycles = 0;
    @(posedge CLK); #1;
    check({tag, "_rdy"}, LEN'(x_ready), LEN'(1));
    x_in = x; x_valid = 1'b1;
    @(posedge CLK); #1;
    x_valid = 1'b0;
    check({tag, "_lat"}, LEN'(bit_valid), LEN'(1));
    while (s_n < max_bits && cycles < BUDGET) begin
      bit_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall) begin
        x_valid = 1'($urandom_range(0, 1));
        x_in    = 16'h8000;
      end
      if (!bit_valid) s_valid_bad = 1;
      if (held && ({bit_out, bit_valid, bit_last} !== prev)) s_stall_bad = 1;
      if (bit_valid && bit_ready) begin
        s_bits[s_n] = bit_out;
        if (bit_last) begin
          s_last_cnt = s_last_cnt + 1;
          s_last_idx = s_n;
        end
        s_n = s_n + 1;
      end
      prev = {bit_out, bit_valid, bit_last};
      held = bit_valid && !bit_ready;
      @(posedge CLK); #1;
      cycles = cycles + 1;
    end
    x_valid = 1'b0;
    bit_ready = 1'b1;
    if (cycles >= BUDGET) s_timeout = 1;
  endtask

  task automatic end_checks(input string tag, input logic [LEN-1:0] exp_bits, input int exp_ones);
    check({tag, "_timeout"}, LEN'(s_timeout), LEN'(0));
    check({tag, "_bits"}, s_bits, exp_bits);
    check({tag, "_ones"}, LEN'($countones(s_bits)), LEN'(exp_ones));
    check({tag, "_nlast"}, LEN'(s_last_cnt), LEN'(1));
    check({tag, "_lastidx"}, LEN'(s_last_idx), LEN'(LEN - 1));
    check({tag, "_validrun"}, LEN'(s_valid_bad), LEN'(0));
    check({tag, "_rdy_after"}, LEN'(x_ready), LEN'(1));
    check({tag, "_bv_after"}, LEN'(bit_valid), LEN'(0));
  endtask

  initial begin
    #3;
    check("rst_x_ready", LEN'(x_ready), LEN'(1));
    check("rst_bit_valid", LEN'(bit_valid), LEN'(0));
    check("rst_bit_last", LEN'(bit_last), LEN'(0));
    check("rst_bit_out", LEN'(bit_out), LEN'(0));
    @(negedge CLK); nRST = 1'b1;
    bit_ready = 1'b1;

    run_stream("zero", 16'h0000, 0, LEN);
    end_checks("zero", pattern(8'h02 >> 1 | 8'h01, 2) & pattern(8'h01, 2), 128);

    run_stream("pos1", 16'h4000, 0, LEN);
    end_checks("pos1", {LEN{1'b1}}, 256);

    run_stream("neg1", 16'hC000, 0, LEN);
    end_checks("neg1", {LEN{1'b0}}, 0);

    run_stream("half", 16'h2000, 0, LEN);
    end_checks("half", pattern(8'h0B, 4), 192);

    run_stream("satp", 16'h7FFF, 0, LEN);
    end_checks("satp", {LEN{1'b1}}, 256);

    run_stream("satn", 16'h8000, 0, LEN);
    end_checks("satn", {LEN{1'b0}}, 0);

    run_stream("qneg", 16'hF000, 0, LEN);
    end_checks("qneg", pattern(8'h4A, 8), 96);

    run_stream("stall", 16'h2000, 1, LEN);
    end_checks("stall", pattern(8'h0B, 4), 192);
    check("stall_hold", LEN'(s_stall_bad), LEN'(0));

    // Abort mid-stream: reset must act without waiting for a clock edge
    run_stream("abort", 16'h0000, 0, 100);
    check("abort_n", LEN'(s_n), LEN'(100));
    check("abort_prefix", LEN'(s_bits[99:0]), LEN'(pattern(8'h01, 2) & {{(LEN-100){1'b0}}, {100{1'b1}}}));
    check("abort_bv_pre", LEN'(bit_valid), LEN'(1));
    nRST = 1'b0;
    #1;
    check("abort_bit_valid", LEN'(bit_valid), LEN'(0));
    check("abort_x_ready", LEN'(x_ready), LEN'(1));
    check("abort_bit_out", LEN'(bit_out), LEN'(0));
    check("abort_bit_last", LEN'(bit_last), LEN'(0));
    @(posedge CLK); #1;
    check("abort_bv_held", LEN'(bit_valid), LEN'(0));
    @(negedge CLK); nRST = 1'b1;

    run_stream("fresh", 16'h0000, 0, LEN);
    check("fresh_first", LEN'(s_bits[0]), LEN'(1));
    end_checks("fresh", pattern(8'h01, 2), 128);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
